uart_rx_sequencer: RTL and testbench
====================================

Name: uart_rx_sequencer

Overview:
- Controller that sequences the UART receive path of the 7-segment/UART control design.
- Detects the start bit on the serial line and generates mid-bit sample strokes.
- Tracks the bit index, assembles the frame LSB-first and checks the stop bit.
- Hands completed bytes to the display/command logic with a one-cycle valid pulse.

Parameters:
- CLKS_PER_BIT, 5208: clock cycles per UART bit (50 MHz / 9600 baud); must be >= 4.
- DATA_BITS, 8: data bits per frame, range 5..8.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- enable  input  1  1 = new frames may start; 0 = ignore new start bits.
- rx_data  output  DATA_BITS  last good received byte.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high in any state other than IDLE.
- bit_cnt  output  4  number of data bits sampled so far in the current frame.
- sample_strobe  output  1  one-cycle pulse at every mid-bit sample point (start, data, stop).

Behaviour:
- Reset values:
  - rx_data = 0, rx_valid = 0, frame_error = 0, busy = 0, bit_cnt = 0, sample_strobe = 0.
  - FSM = IDLE, baud counter = 0.
  - Synchronizer flops and edge-history flop = 1.
- Synchronization:
  - rx passes through a 2-flop synchronizer (rx_s).
  - A falling edge is prev rx_s = 1 and current rx_s = 0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On falling edge with enable = 1: clear the baud counter, go to START.
  - With enable = 0: stay in IDLE.
- START:
  - Counter runs to CLKS_PER_BIT/2 - 1 (integer divide), then sample_strobe pulses.
  - rx_s = 0: clear counter, clear bit_cnt, go to DATA.
  - rx_s = 1: glitch; return to IDLE with no error pulse.
- DATA:
  - Counter runs to CLKS_PER_BIT - 1, then sample_strobe pulses and rx_s is shifted in LSB-first.
  - bit_cnt increments on each sample.
  - When bit_cnt reaches DATA_BITS, go to STOP.
- STOP:
  - At CLKS_PER_BIT - 1, sample_strobe pulses.
  - rx_s = 1: rx_data <= shift register, rx_valid = 1 for the next cycle.
  - rx_s = 0: frame_error = 1 for the next cycle; rx_data holds its old value.
  - Either way go to IDLE and clear bit_cnt.
- Latency: from the first synchronized-low cycle to rx_valid = CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 clocks.
- Back-to-back frames: return to IDLE at the stop-bit midpoint, so a start edge in the next half-bit is caught with no frame lost.
- Line held low after a framing error (break): no retrigger until rx_s goes high and then low again.
- enable dropped mid-frame: the current frame completes normally; enable gates only the IDLE->START transition.
- Reset mid-frame: all state returns to reset values immediately (asynchronous); any partial byte is discarded.
- rx_valid and frame_error are never high in the same cycle; neither is high for more than one cycle.
- Counter width: $clog2(CLKS_PER_BIT); it never wraps past CLKS_PER_BIT - 1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled at CLKS_PER_BIT - 1.
  - Checks even parity over data bits plus the parity bit.
  - Adds output parity_error (1 bit, reset 0): one-cycle pulse in the cycle rx_valid would have asserted.
  - On parity mismatch with a good stop bit: rx_valid stays 0 and rx_data is not updated.
  - A bad stop bit takes priority: frame_error pulses, parity_error stays 0.
  - Latency grows by CLKS_PER_BIT.
- Not defined: no PARITY state, no parity_error port; behaviour exactly as above.

Test Plan:
- Receive 0xA5: CLKS_PER_BIT=16, enable=1, send 8N1 0xA5 -> rx_valid one cycle at edge+8+144+1 clocks, rx_data=0xA5, bit_cnt back to 0, 10 sample_strobe pulses.
- Start glitch: rx low for 4 clocks then high -> no rx_valid, no frame_error, busy drops after the START sample, FSM in IDLE.
- Framing error: send 0x3C with stop bit 0 after a prior 0xA5 -> frame_error pulse, rx_valid stays 0, rx_data remains 0xA5; line held low produces no new frame.
- Reset mid-frame: assert reset during data bit 3 of 0x5A -> outputs 0 immediately; after release, send 0xC3 -> rx_data=0xC3, single rx_valid.
- Back-to-back with enable gating:
  - Send 0x00 then 0xFF with one stop bit between -> two rx_valid pulses, values 0x00 then 0xFF.
  - With enable=0, send 0x11 -> no busy, no valid.
- Parity (UART_RX_PARITY_EN defined):
  - 0x07 with parity bit 1 -> rx_valid, rx_data=0x07.
  - 0x07 with parity bit 0 -> parity_error pulse, rx_data unchanged.

Source files
------------

// File: rtl/uart_rx_sequencer_if.sv
// rtl/uart_rx_sequencer_if.sv - received-byte handoff bundle of the UART receive sequencer
// UART_RX_PARITY_EN adds parity_error to the bundle
interface uart_rx_sequencer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_error;
`ifdef UART_RX_PARITY_EN
  logic                 parity_error;

  modport master (output rx_data, output rx_valid, output frame_error, output parity_error);
  modport slave  (input rx_data, input rx_valid, input frame_error, input parity_error);
`else
  modport master (output rx_data, output rx_valid, output frame_error);
  modport slave  (input rx_data, input rx_valid, input frame_error);
`endif
endinterface

// File: rtl/uart_rx_sequencer.sv
// rtl/uart_rx_sequencer.sv - UART receive sequencer: start detect, mid-bit sampling, LSB-first assembly, stop check
// UART_RX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit
module uart_rx_sequencer #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                rx_i,
  input  logic                enable_i,
  output logic                busy_o,
  output logic [3:0]          bit_cnt_o,
  output logic                sample_strobe_o,
  uart_rx_sequencer_if.master out_if
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_error_q, frame_error_d;
  logic                 strobe_q, strobe_d;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic                 fall_edge;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 parity_error_q, parity_error_d;
`endif

  assign fall_edge = rx_prev_q & ~rx_s_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;
    strobe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d      = par_bit_q;
    parity_error_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (fall_edge && enable_i) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          strobe_d = 1'b1;
          cnt_d    = '0;
          if (!rx_s_q) begin
            bit_cnt_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          strobe_d  = 1'b1;
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_LAST) begin
          strobe_d  = 1'b1;
          cnt_d     = '0;
          par_bit_d = rx_s_q;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          strobe_d  = 1'b1;
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = IDLE;
          // a bad stop bit outranks any other verdict on the frame
          if (!rx_s_q) begin
            frame_error_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bit_q != ^shift_q) begin
            parity_error_d = 1'b1;
          end
`endif
          else begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      strobe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q      <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      rx_meta_q     <= rx_i;
      rx_s_q        <= rx_meta_q;
      rx_prev_q     <= rx_s_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      strobe_q      <= strobe_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q      <= par_bit_d;
      parity_error_q <= parity_error_d;
`endif
    end
  end

  assign busy_o             = (state_q != IDLE);
  assign bit_cnt_o          = bit_cnt_q;
  assign sample_strobe_o    = strobe_q;
  assign out_if.rx_data     = rx_data_q;
  assign out_if.rx_valid    = rx_valid_q;
  assign out_if.frame_error = frame_error_q;
`ifdef UART_RX_PARITY_EN
  assign out_if.parity_error = parity_error_q;
`endif
endmodule

// File: tb/tb_uart_rx_sequencer.sv
// tb/tb_uart_rx_sequencer.sv - self-checking bench for uart_rx_sequencer (honours UART_RX_PARITY_EN)
module tb_uart_rx_sequencer;
  localparam int C  = 16;
  localparam int DB = 8;
  localparam int H  = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // rx driven low -> two synchronizer edges -> half bit -> remaining bits -> registered pulse
  localparam int LAT = 2 + H + (DB + 1 + PB) * C + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       enable = 1'b1;
  logic       busy;
  logic [3:0] bit_cnt;
  logic       strobe;

  uart_rx_sequencer_if #(.DATA_BITS(DB)) rif ();

  uart_rx_sequencer #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .rx_i           (rx),
    .enable_i       (enable),
    .busy_o         (busy),
    .bit_cnt_o      (bit_cnt),
    .sample_strobe_o(strobe),
    .out_if         (rif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0, n_fe = 0, n_pe = 0, n_strobe = 0, n_busy = 0;
  logic [DB-1:0] vq[$];
  int vcyc[$];
  bit overlap = 0, wide = 0;
  logic prev_v = 1'b0, prev_f = 1'b0, prev_p = 1'b0;

  always @(negedge clk) begin
    logic pe;
`ifdef UART_RX_PARITY_EN
    pe = rif.parity_error;
`else
    pe = 1'b0;
`endif
    if (!reset) begin
      if (rif.rx_valid) begin
        n_valid++;
        vq.push_back(rif.rx_data);
        vcyc.push_back(cyc);
      end
      if (rif.frame_error) n_fe++;
      if (pe) n_pe++;
      if (strobe) n_strobe++;
      if (busy) n_busy++;
      if ((rif.rx_valid && rif.frame_error) || (rif.rx_valid && pe) || (rif.frame_error && pe)) overlap = 1;
      if ((rif.rx_valid && prev_v) || (rif.frame_error && prev_f) || (pe && prev_p)) wide = 1;
    end
    prev_v = rif.rx_valid;
    prev_f = rif.frame_error;
    prev_p = pe;
  end

  int passed = 0, total = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input logic par);
    rx = 1'b0;
    step(C);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      step(C);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    step(C);
`endif
    rx = stop_bit;
    step(C);
  endtask

  initial begin
    int bv, bf, bp, bs, bb, bq, c0;
    logic [DB-1:0] exp_data;
    logic [DB-1:0] exp_q[$];
    int exp_fe;
    logic [DB-1:0] d;
    logic [DB-1:0] pat;
    bit good, en;

    exp_data = '0;
    step(3);
    chk("rst_rx_data", rif.rx_data, 0);
    chk("rst_rx_valid", rif.rx_valid, 0);
    chk("rst_frame_error", rif.frame_error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_strobe", strobe, 0);
    reset = 1'b0;
    step(4);

    // single 0xA5 frame
    bv = n_valid; bs = n_strobe; bq = vq.size(); c0 = cyc;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    exp_data = 8'hA5;
    step(4);
    chk("a5_valid_cnt", n_valid - bv, 1);
    chk("a5_data", rif.rx_data, exp_data);
    chk("a5_latency", vcyc.size() > bq ? vcyc[bq] - c0 : -1, LAT);
    chk("a5_strobes", n_strobe - bs, DB + 2 + PB);
    chk("a5_bit_cnt", bit_cnt, 0);
    chk("a5_busy", busy, 0);

    // start glitch
    bv = n_valid; bf = n_fe; bs = n_strobe; bb = n_busy;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(2 * C);
    chk("glitch_valid", n_valid - bv, 0);
    chk("glitch_fe", n_fe - bf, 0);
    chk("glitch_strobe", n_strobe - bs, 1);
    chk("glitch_busy_cycles", n_busy - bb, H);
    chk("glitch_idle", busy, 0);

    // framing error, then line held low
    bv = n_valid; bf = n_fe;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    bb = n_busy;
    step(3 * C);
    chk("fe_pulse", n_fe - bf, 1);
    chk("fe_no_valid", n_valid - bv, 0);
    chk("fe_data_held", rif.rx_data, exp_data);
    chk("fe_break_no_retrigger", n_busy - bb, 0);
    rx = 1'b1;
    step(C);

    // reset during data bit 3 of 0x5A
    pat = 8'h5A;
    rx = 1'b0;
    step(C);
    for (int i = 0; i < 3; i++) begin
      rx = pat[i];
      step(C);
    end
    rx = pat[3];
    step(6);
    chk("mid_bit_cnt", bit_cnt, 3);
    chk("mid_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_bit_cnt", bit_cnt, 0);
    chk("async_rst_data", rif.rx_data, 0);
    chk("async_rst_valid", rif.rx_valid, 0);
    exp_data = '0;
    rx = 1'b1;
    step(2);
    reset = 1'b0;
    step(2 * C);
    bv = n_valid;
    send_frame(8'hC3, 1'b1, ^8'hC3);
    exp_data = 8'hC3;
    step(4);
    chk("post_rst_valid_cnt", n_valid - bv, 1);
    chk("post_rst_data", rif.rx_data, exp_data);

    // back-to-back frames
    bv = n_valid; bq = vq.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    exp_data = 8'hFF;
    step(4);
    chk("b2b_valid_cnt", n_valid - bv, 2);
    chk("b2b_first", vq.size() > bq ? vq[bq] : 'x, 8'h00);
    chk("b2b_second", vq.size() > bq + 1 ? vq[bq + 1] : 'x, 8'hFF);

    // enable low ignores a whole frame
    enable = 1'b0;
    bv = n_valid; bb = n_busy;
    send_frame(8'h11, 1'b1, ^8'h11);
    step(4);
    chk("disabled_busy", n_busy - bb, 0);
    chk("disabled_valid", n_valid - bv, 0);
    enable = 1'b1;
    step(C);

    // randomized frames against the reference model
    bv = n_valid; bf = n_fe; bq = vq.size(); exp_fe = 0;
    for (int k = 0; k < 10; k++) begin
      d = DB'($urandom);
      good = ($urandom_range(0, 4) != 0);
      en = ($urandom_range(0, 3) != 0);
      enable = en;
      step(1);
      send_frame(d, good, ^d);
      if (en) begin
        if (good) begin
          exp_q.push_back(d);
          exp_data = d;
        end else begin
          exp_fe++;
        end
      end
      rx = 1'b1;
      step(C + $urandom_range(0, C));
    end
    enable = 1'b1;
    chk("rand_valid_cnt", n_valid - bv, exp_q.size());
    chk("rand_fe_cnt", n_fe - bf, exp_fe);
    for (int k = 0; k < exp_q.size(); k++)
      chk("rand_byte", vq.size() > bq + k ? vq[bq + k] : 'x, exp_q[k]);
    chk("rand_last_data", rif.rx_data, exp_data);

`ifdef UART_RX_PARITY_EN
    bv = n_valid; bp = n_pe;
    send_frame(8'h07, 1'b1, 1'b1);
    exp_data = 8'h07;
    step(4);
    chk("par_ok_valid", n_valid - bv, 1);
    chk("par_ok_data", rif.rx_data, exp_data);
    chk("par_ok_no_pe", n_pe - bp, 0);
    bv = n_valid; bp = n_pe;
    send_frame(8'h38, 1'b1, 1'b0);
    step(4);
    chk("par_bad_pe", n_pe - bp, 1);
    chk("par_bad_no_valid", n_valid - bv, 0);
    chk("par_bad_data_held", rif.rx_data, exp_data);
    bf = n_fe; bp = n_pe;
    send_frame(8'h07, 1'b0, 1'b0);
    rx = 1'b1;
    step(C);
    chk("par_stop_priority_fe", n_fe - bf, 1);
    chk("par_stop_priority_pe", n_pe - bp, 0);
`else
    bp = n_pe;
    chk("no_parity_pulses", bp, 0);
`endif

    chk("pulse_overlap", overlap, 0);
    chk("pulse_width", wide, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
